// File: rtl/io_panel.sv
// Board I/O front end: tick divider, input sync/debounce with press pulses,
// LED mirror, and hex display driven both in parallel and as a scanned bus.
module io_panel #(
  parameter int unsigned CLK_DIV        = 1000,
  parameter int unsigned N_SW           = 4,
  parameter int unsigned N_BTN          = 4,
  parameter int unsigned DEBOUNCE_TICKS = 16,
  parameter int unsigned N_DIGITS       = 2,
  parameter bit          ACTIVE_LOW     = 1'b0
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [N_SW-1:0]       Slide_Switch,
  input  logic [N_BTN-1:0]      Button,
  input  logic [4*N_DIGITS-1:0] Result,
  input  logic [N_DIGITS-1:0]   Dp,
  input  logic [3:0]            State,
  input  logic                  Blank,
  output logic [N_SW-1:0]       User_Input0,
  output logic [N_BTN-1:0]      User_Input1,
  output logic [N_BTN-1:0]      Button_Press,
  output logic                  Tick,
  output logic [3:0]            LED,
  output logic [8*N_DIGITS-1:0] Segment_Par,
  output logic [7:0]            Segment_Scan,
  output logic [N_DIGITS-1:0]   Digit_En
);

  localparam int unsigned N_IN  = N_SW + N_BTN;
  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned SEG_W = 8 * N_DIGITS;

  logic [CNT_W-1:0]      div_q, div_d;
  logic                  tick_q, tick_d;
  logic [N_IN-1:0]       sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d;
  logic [DB_W-1:0]       dbc_q [N_IN];
  logic [DB_W-1:0]       dbc_d [N_IN];
  logic [N_BTN-1:0]      btn_last_q, btn_last_d, press_q, press_d;
  logic [3:0]            led_q, led_d;
  logic [4*N_DIGITS-1:0] res_q, res_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  logic                  blank_q, blank_d, valid_q, valid_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SEG_W-1:0]      seg_par_q, seg_par_d, seg_act_c;
  logic [7:0]            seg_scan_q, seg_scan_d, scan_act_c;
  logic [N_DIGITS-1:0]   dig_en_q, dig_en_d, en_act_c;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Tick is registered one count early so it is high while the counter sits at CLK_DIV-1.
  always_comb begin
    div_d  = (div_q == CNT_W'(CLK_DIV - 1)) ? '0 : div_q + CNT_W'(1);
    tick_d = (div_q == CNT_W'(CLK_DIV - 2));
  end

  // Synchronise switches (low bits) and buttons (high bits), then debounce on Tick.
  always_comb begin
    sync1_d    = {Button, Slide_Switch};
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    dbc_d      = dbc_q;
    if (tick_q) begin
      for (int i = 0; i < int'(N_IN); i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (dbc_q[i] == DB_W'(DEBOUNCE_TICKS - 1)) begin
            deb_d[i] = sync2_q[i];
            dbc_d[i] = '0;
          end else begin
            dbc_d[i] = dbc_q[i] + DB_W'(1);
          end
        end else begin
          dbc_d[i] = '0;
        end
      end
    end
    btn_last_d = deb_q[N_IN-1:N_SW];
    press_d    = deb_q[N_IN-1:N_SW] & ~btn_last_q;
    led_d      = State;
  end

  // Snapshot display inputs on Tick; scan index holds at 0 until the first snapshot lands.
  always_comb begin
    res_d   = res_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    if (tick_q) begin
      res_d   = Result;
      dp_d    = Dp;
      blank_d = Blank;
      valid_d = 1'b1;
      if (valid_q) idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Decode the snapshot and apply output polarity.
  always_comb begin
    seg_act_c  = '0;
    scan_act_c = '0;
    en_act_c   = '0;
    if (valid_q && !blank_q) begin
      for (int k = 0; k < int'(N_DIGITS); k++)
        seg_act_c[8*k +: 8] = {dp_q[k], hex7(res_q[4*k +: 4])};
    end
    for (int k = 0; k < int'(N_DIGITS); k++)
      if (idx_q == IDX_W'(k)) scan_act_c = seg_act_c[8*k +: 8];
    if (valid_q) en_act_c = N_DIGITS'(1) << idx_q;
    seg_par_d  = seg_act_c ^ {SEG_W{ACTIVE_LOW}};
    seg_scan_d = scan_act_c ^ {8{ACTIVE_LOW}};
    dig_en_d   = en_act_c ^ {N_DIGITS{ACTIVE_LOW}};
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      div_q      <= '0;
      tick_q     <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      for (int i = 0; i < int'(N_IN); i++) dbc_q[i] <= '0;
      btn_last_q <= '0;
      press_q    <= '0;
      led_q      <= '0;
      res_q      <= '0;
      dp_q       <= '0;
      blank_q    <= 1'b0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      seg_par_q  <= {SEG_W{ACTIVE_LOW}};
      seg_scan_q <= {8{ACTIVE_LOW}};
      dig_en_q   <= {N_DIGITS{ACTIVE_LOW}};
    end else begin
      div_q      <= div_d;
      tick_q     <= tick_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      dbc_q      <= dbc_d;
      btn_last_q <= btn_last_d;
      press_q    <= press_d;
      led_q      <= led_d;
      res_q      <= res_d;
      dp_q       <= dp_d;
      blank_q    <= blank_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      seg_par_q  <= seg_par_d;
      seg_scan_q <= seg_scan_d;
      dig_en_q   <= dig_en_d;
    end
  end

  assign User_Input0  = deb_q[N_SW-1:0];
  assign User_Input1  = deb_q[N_IN-1:N_SW];
  assign Button_Press = press_q;
  assign Tick         = tick_q;
  assign LED          = led_q;
  assign Segment_Par  = seg_par_q;
  assign Segment_Scan = seg_scan_q;
  assign Digit_En     = dig_en_q;

endmodule

// File: doc/io_panel.md
Name: io_panel

Overview:
Parametrised board I/O front end between the physical switches, buttons, LEDs and 7-segment displays and the processor core. It generates a 1-cycle tick strobe from the system clock, synchronises and debounces switches and buttons, and emits one-cycle button-press pulses. It drives N hex digits both as parallel segment buses and as a time-multiplexed scan bus. Every register runs on the single system clock; the tick is a clock enable, not a derived clock.

Parameters:
CLK_DIV, 1000, system-clock cycles per tick (10 MHz -> 10 kHz); must be >= 2
N_SW, 4, number of slide switches
N_BTN, 4, number of push buttons
DEBOUNCE_TICKS, 16, consecutive ticks an input must hold a new value before it is accepted; must be >= 1
N_DIGITS, 2, number of hex digits displayed
ACTIVE_LOW, 0, 1 = invert all Segment_Par, Segment_Scan and Digit_En outputs

Ports:
CLK  in  1  system clock, all logic on rising edge
Reset  in  1  asynchronous, active-high reset
Slide_Switch  in  N_SW  raw switch pins, asynchronous
Button  in  N_BTN  raw button pins, asynchronous, 1 = pressed
Result  in  4*N_DIGITS  value to display; digit k = Result[4k+3:4k]
Dp  in  N_DIGITS  decimal point per digit
State  in  4  core state, mirrored to LED
Blank  in  1  1 = all segments off
User_Input0  out  N_SW  debounced switch levels
User_Input1  out  N_BTN  debounced button levels
Button_Press  out  N_BTN  one-CLK pulse on debounced 0->1
Tick  out  1  one-CLK strobe every CLK_DIV cycles
LED  out  4  registered copy of State
Segment_Par  out  8*N_DIGITS  digit k on bits [8k+7:8k]
Segment_Scan  out  8  segments of the currently scanned digit
Digit_En  out  N_DIGITS  one-hot scan select

Behaviour:
- Reset (async, active-high) clears all registers. While Reset is high and until the first Tick after its release: User_Input0 = 0, User_Input1 = 0, Button_Press = 0, Tick = 0, LED = 0, all segments at their inactive level, Digit_En all inactive.
- Tick divider: counter 0..CLK_DIV-1, cleared by reset. Tick = 1 in the cycle the counter equals CLK_DIV-1, then the counter wraps to 0. The first Tick is CLK_DIV cycles after reset release.
- Synchroniser: two flops per switch and per button bit, so each input adds 2 cycles of latency.
- Debounce, per bit, evaluated only on Tick:
  - If the synced value differs from the debounced value, the counter increments.
  - If they are equal, the counter clears, so a bounce restarts the count.
  - When the counter reaches DEBOUNCE_TICKS, the debounced value takes the synced value on that same Tick edge and the counter clears.
- Button_Press[i] is high for exactly one CLK cycle, the cycle after User_Input1[i] goes 0->1. A release produces no pulse.
- LED updates to State on every CLK edge, 1-cycle latency.
- Display snapshot:
  - Result, Dp and Blank are sampled on each Tick.
  - The decoders use only the snapshot, so displays change only on tick boundaries.
  - A valid flag sets on the first Tick; segments stay inactive until it is set.
- Segment encoding, bit order {dp,g,f,e,d,c,b,a}, active-high before the ACTIVE_LOW inversion:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - bit 7 = snapshot Dp[k]
  - a snapshot Blank of 1 forces all 8 bits of every digit to 0
- Scan: the digit index advances by one on each Tick and wraps from N_DIGITS-1 to 0. Digit_En is one-hot on the index. Segment_Scan equals the Segment_Par slice of that index, driven from the same register stage. Index starts at 0 after reset. For N_DIGITS=1, Digit_En is constantly active after the first Tick.
- Segment_Par, Segment_Scan and Digit_En are registered outputs that update 1 cycle after the Tick edge.
- Reset asserted mid-debounce or mid-scan clears everything immediately. There is no pulse on reset release even if a button is held; a held button is accepted only after a full debounce, then pulses once.

Test Plan:
- Use CLK_DIV=4, DEBOUNCE_TICKS=3, N_DIGITS=2 for all scenarios below.
- Reset release -> Tick first high at cycle 4, then every 4 cycles; all outputs 0 or inactive before the first Tick.
- Button[0] held at 1 -> User_Input1[0]=1 after the 3rd qualifying Tick; Button_Press[0] is a single-cycle pulse; release gives no pulse.
- Button[1] bounces 1,0 around Tick 2 of the count -> counter restarts; accepted only after 3 stable ticks; exactly one pulse.
- Result=8'hA5, Dp=2'b10 -> Segment_Par = {F7,6D} after the next Tick; Segment_Scan alternates 6D/F7 with Digit_En 01/10 on successive Ticks.
- Blank=1 -> all segments 00 after the next Tick. With ACTIVE_LOW=1, Blank=1 gives FF and the Digit_En values are inverted.
- Reset asserted mid-scan with Button held -> outputs clear asynchronously; after release, no Button_Press until a full debounce completes.
